// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state-decoded datapath controls plus ALU control decode.
// Write/load enables and status pulses are gated by rst_n so they drop the instant reset asserts.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               iorD,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memtoReg,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         pcSrc,
    output logic               pcEn,
    output logic [2:0]         aluCtrl,
    output logic               instrDone,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       pcWrite, branch, unreachable;
    logic [1:0] aluOp;
    logic       memWriteRaw, irWriteRaw, regWriteRaw, instrDoneRaw, illegalOpRaw;
    logic [2:0] aluDec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = FETCH;
        iorD         = 1'b0;
        memWriteRaw  = 1'b0;
        irWriteRaw   = 1'b0;
        regDst       = 1'b0;
        memtoReg     = 1'b0;
        regWriteRaw  = 1'b0;
        aluSrcA      = 1'b0;
        aluSrcB      = 2'b00;
        pcSrc        = 2'b00;
        pcWrite      = 1'b0;
        branch       = 1'b0;
        aluOp        = 2'b00;
        instrDoneRaw = 1'b0;
        illegalOpRaw = 1'b0;
        unreachable  = 1'b0;
        case (state_q)
            FETCH: begin
                aluSrcB    = 2'b01;
                irWriteRaw = 1'b1;
                pcWrite    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d      = FETCH;
                        illegalOpRaw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                // The IR still holds the opcode here, so lw/sw is re-decoded from op.
                state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoReg     = 1'b1;
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
            end
            MEMWRITE: begin
                iorD         = 1'b1;
                memWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regDst       = 1'b1;
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
            end
            BRANCH: begin
                aluSrcA      = 1'b1;
                aluOp        = 2'b01;
                pcSrc        = 2'b01;
                branch       = 1'b1;
                instrDoneRaw = 1'b1;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regWriteRaw  = 1'b1;
                instrDoneRaw = 1'b1;
            end
            JUMP: begin
                pcSrc        = 2'b10;
                pcWrite      = 1'b1;
                instrDoneRaw = 1'b1;
            end
            default: unreachable = 1'b1;
        endcase
    end

    always_comb begin
        aluDec = 3'b010;
        case (aluOp)
            2'b01: aluDec = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: aluDec = 3'b010;
                    6'b100010: aluDec = 3'b110;
                    6'b100100: aluDec = 3'b000;
                    6'b100101: aluDec = 3'b001;
                    6'b101010: aluDec = 3'b111;
                    default:   aluDec = 3'b010;
                endcase
            end
            default: aluDec = 3'b010;
        endcase
    end

    assign aluCtrl   = unreachable ? 3'b000 : aluDec;
    assign memWrite  = memWriteRaw  & rst_n;
    assign irWrite   = irWriteRaw   & rst_n;
    assign regWrite  = regWriteRaw  & rst_n;
    assign instrDone = instrDoneRaw & rst_n;
    assign illegalOp = illegalOpRaw & rst_n;
    // zero only matters in BRANCH, and feeds pcEn without a register in between.
    assign pcEn      = (pcWrite | (branch & zero)) & rst_n;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected per-cycle control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, pcSrc;
    logic       pcEn;
    logic [2:0] aluCtrl;
    logic       instrDone, illegalOp;
    logic [3:0] state;

    typedef struct packed {
        logic       iorD;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic [2:0] aluCtrl;
        logic       instrDone;
        logic       illegalOp;
        logic [3:0] state;
    } ctrl_t;

    ctrl_t expQ[$];
    int    tests = 0;
    int    fails = 0;
    bit    monOn = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
        .memtoReg(memtoReg), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcSrc(pcSrc), .pcEn(pcEn), .aluCtrl(aluCtrl), .instrDone(instrDone),
        .illegalOp(illegalOp), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isSupported(logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    // ALU operation an R-type instruction asks for, by function code.
    function automatic logic [2:0] rTypeAlu(logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Datapath controls the instruction needs in a given step, keyed by step name number.
    function automatic ctrl_t expectCtrl(int st, logic [5:0] fn, logic z, bit ill);
        ctrl_t c;
        c = '0;
        c.state   = 4'(st);
        c.aluCtrl = 3'b010;
        case (st)
            0:  begin c.aluSrcB = 2'b01; c.irWrite = 1; c.pcEn = 1; end
            1:  begin c.aluSrcB = 2'b11; c.illegalOp = ill; end
            2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            3:  c.iorD = 1;
            4:  begin c.memtoReg = 1; c.regWrite = 1; c.instrDone = 1; end
            5:  begin c.iorD = 1; c.memWrite = 1; c.instrDone = 1; end
            6:  begin c.aluSrcA = 1; c.aluCtrl = rTypeAlu(fn); end
            7:  begin c.regDst = 1; c.regWrite = 1; c.instrDone = 1; end
            8:  begin c.aluSrcA = 1; c.pcSrc = 2'b01; c.pcEn = z; c.aluCtrl = 3'b110; c.instrDone = 1; end
            9:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            10: begin c.regWrite = 1; c.instrDone = 1; end
            11: begin c.pcSrc = 2'b10; c.pcEn = 1; c.instrDone = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic void buildSeq(logic [5:0] o, ref int seq[$]);
        seq = {0, 1};
        case (o)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = {seq, 6, 7};
            6'b000100: seq = {seq, 8};
            6'b001000: seq = {seq, 9, 10};
            6'b000010: seq = {seq, 11};
            default:   ;
        endcase
    endfunction

    function automatic ctrl_t sampleDut();
        return ctrl_t'({iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA,
                        aluSrcB, pcSrc, pcEn, aluCtrl, instrDone, illegalOp, state});
    endfunction

    always @(negedge clk) begin
        if (rst_n && monOn) begin
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_cycle got=%h required=<no expected entry>", sampleDut());
            end else begin
                ctrl_t e;
                ctrl_t g;
                e = expQ.pop_front();
                g = sampleDut();
                if (g !== e) begin
                    fails++;
                    $display("[TB] FAIL ctrl_st%0d got=%h required=%h", e.state, g, e);
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [31:0] got, logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("[TB] FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic checkResetForced(string name);
        checkOutput({name, "_forced"},
                    {26'd0, memWrite, irWrite, regWrite, pcEn, instrDone, illegalOp}, 32'd0);
        checkOutput({name, "_state"}, {28'd0, state}, 32'd0);
    endtask

    // Runs one instruction, entered at posedge+1 of its FETCH cycle; leaves at posedge+1 after.
    // toggleZ flips zero mid-cycle; abortAt>=0 drops rst_n after the check of that step.
    task automatic applyStimulus(logic [5:0] o, logic [5:0] fn, int zeroSel, bit toggleZ, int abortAt);
        int  seq[$];
        bit  ill;
        ill = !isSupported(o);
        buildSeq(o, seq);
        op    = o;
        funct = fn;
        foreach (seq[i]) begin
            zero = (zeroSel == 2) ? 1'($urandom_range(0, 1)) : 1'(zeroSel);
            expQ.push_back(expectCtrl(seq[i], fn, toggleZ ? ~zero : zero, ill));
            if (toggleZ) begin
                #2 zero = ~zero;
            end
            if (seq[i] == abortAt) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 checkResetForced("abort");
                checkOutput("abort_memWrite", {31'd0, memWrite}, 32'd0);
                @(negedge clk);
                checkResetForced("abort_hold");
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] functs[6];
        logic [5:0] ops[6];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        rst_n = 1'b0;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        @(negedge clk);
        checkResetForced("reset");
        @(negedge clk);
        checkResetForced("reset2");
        @(posedge clk);
        #1 rst_n = 1'b1;
        monOn = 1;

        applyStimulus(6'b100011, 6'd0, 2, 0, -1);
        foreach (functs[i]) applyStimulus(6'b000000, functs[i], 2, 0, -1);
        applyStimulus(6'b000100, 6'd0, 1, 0, -1);
        applyStimulus(6'b000100, 6'd0, 0, 0, -1);
        applyStimulus(6'b000100, 6'd0, 0, 1, -1);
        applyStimulus(6'b000100, 6'd0, 1, 1, -1);
        applyStimulus(6'b111111, 6'd0, 2, 0, -1);
        applyStimulus(6'b000010, 6'd0, 2, 0, -1);
        applyStimulus(6'b001000, 6'd0, 2, 0, -1);
        applyStimulus(6'b101011, 6'd0, 2, 0, 5);
        applyStimulus(6'b000010, 6'd0, 2, 0, -1);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] o;
            logic [5:0] fn;
            int pick;
            pick = $urandom_range(0, 7);
            if (pick < 6) begin
                o = ops[pick];
            end else begin
                do o = 6'($urandom_range(0, 63)); while (isSupported(o));
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
            applyStimulus(o, fn, 2, 1'($urandom_range(0, 1)), -1);
        end

        monOn = 0;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
